// File: rtl/dvp_decode_pkg.sv
// Shared types and constants for the DVP pixel decoder.
//   mode_e  : pixel assembly mode, latched at each frame start
//   BAR_RGB : colour-bar table, index 0 is the left-most bar
package dvp_decode_pkg;

  typedef enum logic [1:0] {
    MODE_RGB565 = 2'd0,
    MODE_RAW8   = 2'd1,
    MODE_GRID   = 2'd2,
    MODE_BAR    = 2'd3
  } mode_e;

  // Packed so that BAR_RGB[0] is white and BAR_RGB[7] is black.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000,  // 7 black
    24'h0000FF,  // 6 blue
    24'hFF0000,  // 5 red
    24'hFF00FF,  // 4 magenta
    24'h00FF00,  // 3 green
    24'h00FFFF,  // 2 cyan
    24'hFFFF00,  // 1 yellow
    24'hFFFFFF   // 0 white
  };

  // Frame-wait counter width; FRAME_WAIT is limited to 1..127.
  localparam int FRAME_CNT_W = 7;

endpackage

// File: rtl/dvp_pattern_gen.sv
// Pixel colour generator.
// Maps the assembled bytes (or the pixel/line position for the synthetic
// modes) to a 24-bit {R,G,B} value and holds it in an output register that
// only updates on pix_en_i, so rgb_o keeps its value between strobes.
//   clk, rst_n      : clock, synchronous active-low reset
//   pix_en_i        : a pixel completes this cycle
//   mode_i          : latched frame mode
//   byte0_i/byte1_i : first and current byte (byte1_i alone in RAW8)
//   hcnt_i/vcnt_i   : position of the completing pixel
//   rgb_o           : registered pixel colour
module dvp_pattern_gen
  import dvp_decode_pkg::*;
#(
  parameter int CNT_W     = 12,
  parameter int GRID_LOG2 = 6,
  parameter int BAR_LOG2  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en_i,
  input  mode_e            mode_i,
  input  logic [7:0]       byte0_i,
  input  logic [7:0]       byte1_i,
  input  logic [CNT_W-1:0] hcnt_i,
  input  logic [CNT_W-1:0] vcnt_i,
  output logic [23:0]      rgb_o
);

  logic [23:0] pix;
  logic [2:0]  bar_idx;
  logic [23:0] rgb_d, rgb_q;
  logic        unused_cnt_bits;

  // Only a few position bits select grid squares and bars.
  assign unused_cnt_bits = ^{hcnt_i, vcnt_i};

  always_comb begin
    pix     = '0;
    bar_idx = hcnt_i[BAR_LOG2+2:BAR_LOG2];
    case (mode_i)
      MODE_RGB565: pix = {byte0_i[7:3], 3'b000,
                          byte0_i[2:0], byte1_i[7:5], 2'b00,
                          byte1_i[4:0], 3'b000};
      MODE_RAW8:   pix = {byte1_i, byte1_i, byte1_i};
      MODE_GRID:   pix = (hcnt_i[GRID_LOG2] ^ vcnt_i[GRID_LOG2]) ? 24'h000000 : 24'hFFFFFF;
      MODE_BAR:    pix = BAR_RGB[bar_idx];
      default:     pix = '0;
    endcase
    rgb_d = pix_en_i ? pix : rgb_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rgb_q <= '0;
    else        rgb_q <= rgb_d;
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/dvp_pixel_decode.sv
// DVP camera front end: registers the sensor bus, assembles bytes into
// 24-bit pixels, tracks line/frame geometry and gates output until
// FRAME_WAIT frame starts have been seen.
//   cmos_pclk_i, rst_n_i          : pixel clock, synchronous active-low reset
//   cmos_href_i/vsync_i/data_i    : raw sensor bus
//   mode_i                        : pixel mode, takes effect at next frame start
//   vs_o, hs_o, de_o, rgb_o       : aligned output stream
//   hcnt_o, vcnt_o                : position of the pixel on rgb_o
//   line_len_o, frame_lines_o     : geometry of last completed line/frame
//   out_en_o                      : frame wait elapsed (sticky until reset)
//   odd_line_o                    : a 2-byte line ended on a half pixel
//
// Stream contract: de_o is a one-cycle strobe that qualifies rgb_o, hcnt_o
// and vcnt_o. There is no back-pressure; the consumer must take every
// strobe. Pipeline is pins -> S1 register -> output register, so a pixel's
// last byte on the pins in cycle n shows up on de_o/rgb_o in cycle n+2.
module dvp_pixel_decode
  import dvp_decode_pkg::*;
#(
  parameter int DW         = 8,
  parameter int FRAME_WAIT = 15,
  parameter int CNT_W      = 12,
  parameter int VS_INVERT  = 1,
  parameter int GRID_LOG2  = 6,
  parameter int BAR_LOG2   = 7
) (
  input  logic             cmos_pclk_i,
  input  logic             rst_n_i,
  input  logic             cmos_href_i,
  input  logic             cmos_vsync_i,
  input  logic [DW-1:0]    cmos_data_i,
  input  logic [1:0]       mode_i,
  output logic             vs_o,
  output logic             hs_o,
  output logic             de_o,
  output logic [23:0]      rgb_o,
  output logic [CNT_W-1:0] hcnt_o,
  output logic [CNT_W-1:0] vcnt_o,
  output logic [CNT_W-1:0] line_len_o,
  output logic [CNT_W-1:0] frame_lines_o,
  output logic             out_en_o,
  output logic             odd_line_o
);

  localparam logic [FRAME_CNT_W-1:0] FW      = FRAME_CNT_W'(FRAME_WAIT);
  localparam logic [CNT_W-1:0]       CNT_MAX = '1;

  // S1 and edge-detect registers
  logic             href1_d, href1_q, vs1_d, vs1_q;
  logic [7:0]       data1_d, data1_q;
  logic             href2_d, href2_q, vs2_d, vs2_q;
  // Assembly and geometry state
  mode_e            mode_d, mode_q;
  logic             phase_d, phase_q;
  logic [7:0]       byte0_d, byte0_q;
  logic [CNT_W-1:0] hcnt_d, hcnt_q, vcnt_d, vcnt_q;
  logic [CNT_W-1:0] line_len_d, line_len_q, frame_lines_d, frame_lines_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_d, frame_cnt_q;
  logic             out_en_d, out_en_q;
  // Output stage
  logic             vs_out_d, vs_out_q, hs_out_d, hs_out_q, de_d, de_q;
  logic [CNT_W-1:0] hcnt_out_d, hcnt_out_q, vcnt_out_d, vcnt_out_q;
  logic             odd_d, odd_q;

  logic             vs_start, line_end, two_byte, pixel_done;

  always_comb begin
    href1_d = cmos_href_i;
    vs1_d   = (VS_INVERT != 0) ? ~cmos_vsync_i : cmos_vsync_i;
    data1_d = cmos_data_i[7:0];
    href2_d = href1_q;
    vs2_d   = vs1_q;

    vs_start   = vs1_q & ~vs2_q;
    line_end   = href2_q & ~href1_q;
    two_byte   = (mode_q != MODE_RAW8);
    pixel_done = href1_q & (~two_byte | phase_q);

    mode_d  = vs_start ? mode_e'(mode_i) : mode_q;
    // Phase is 0 on the first byte of a pair; RAW8 keeps it at 0.
    phase_d = href1_q & two_byte & ~phase_q;
    byte0_d = (href1_q & ~phase_q) ? data1_q : byte0_q;

    hcnt_d = hcnt_q;
    if (!href1_q)                             hcnt_d = '0;
    else if (pixel_done && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 1'b1;

    // Frame start has priority over a coincident line end.
    vcnt_d = vcnt_q;
    if (vs_start)                            vcnt_d = '0;
    else if (line_end && vcnt_q != CNT_MAX)  vcnt_d = vcnt_q + 1'b1;

    // hcnt only counts completed pixels, so a dropped half pixel is excluded.
    line_len_d    = line_end ? hcnt_q : line_len_q;
    frame_lines_d = vs_start ? vcnt_q : frame_lines_q;

    frame_cnt_d = frame_cnt_q;
    if (vs_start && frame_cnt_q != FW) frame_cnt_d = frame_cnt_q + 1'b1;
    out_en_d = out_en_q | (vs_start & (frame_cnt_d == FW));

    // Gate with the next-state enable so the enabling frame's vsync passes.
    vs_out_d   = vs1_q & out_en_d;
    hs_out_d   = href1_q & out_en_d;
    de_d       = pixel_done & out_en_d;
    hcnt_out_d = hcnt_q;
    vcnt_out_d = vcnt_q;
    odd_d      = line_end & two_byte & phase_q;
  end

  always_ff @(posedge cmos_pclk_i) begin
    if (!rst_n_i) begin
      href1_q       <= 1'b0;
      vs1_q         <= 1'b0;
      data1_q       <= '0;
      href2_q       <= 1'b0;
      vs2_q         <= 1'b0;
      mode_q        <= MODE_RGB565;
      phase_q       <= 1'b0;
      byte0_q       <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      frame_cnt_q   <= '0;
      out_en_q      <= 1'b0;
      vs_out_q      <= 1'b0;
      hs_out_q      <= 1'b0;
      de_q          <= 1'b0;
      hcnt_out_q    <= '0;
      vcnt_out_q    <= '0;
      odd_q         <= 1'b0;
    end else begin
      href1_q       <= href1_d;
      vs1_q         <= vs1_d;
      data1_q       <= data1_d;
      href2_q       <= href2_d;
      vs2_q         <= vs2_d;
      mode_q        <= mode_d;
      phase_q       <= phase_d;
      byte0_q       <= byte0_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      frame_cnt_q   <= frame_cnt_d;
      out_en_q      <= out_en_d;
      vs_out_q      <= vs_out_d;
      hs_out_q      <= hs_out_d;
      de_q          <= de_d;
      hcnt_out_q    <= hcnt_out_d;
      vcnt_out_q    <= vcnt_out_d;
      odd_q         <= odd_d;
    end
  end

  dvp_pattern_gen #(
    .CNT_W     (CNT_W),
    .GRID_LOG2 (GRID_LOG2),
    .BAR_LOG2  (BAR_LOG2)
  ) u_pattern_gen (
    .clk      (cmos_pclk_i),
    .rst_n    (rst_n_i),
    .pix_en_i (pixel_done),
    .mode_i   (mode_q),
    .byte0_i  (byte0_q),
    .byte1_i  (data1_q),
    .hcnt_i   (hcnt_q),
    .vcnt_i   (vcnt_q),
    .rgb_o    (rgb_o)
  );

  assign vs_o          = vs_out_q;
  assign hs_o          = hs_out_q;
  assign de_o          = de_q;
  assign hcnt_o        = hcnt_out_q;
  assign vcnt_o        = vcnt_out_q;
  assign line_len_o    = line_len_q;
  assign frame_lines_o = frame_lines_q;
  assign out_en_o      = out_en_q;
  assign odd_line_o    = odd_q;

endmodule

// File: tb/tb_dvp_pixel_decode.sv
module tb_dvp_pixel_decode;

  localparam int FW = 3;
  localparam int CW = 12;
  localparam int GL = 2;
  localparam int BL = 1;
  // Expected entry: {rgb[75:52], hcnt[51:40], vcnt[39:28], cycle[27:8], hs_pos[7:0]}
  localparam int EW = 76;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic href, vsync;
  logic [7:0] data;
  logic [1:0] mode;
  logic vs_o, hs_o, de_o, out_en_o, odd_line_o;
  logic [23:0] rgb_o;
  logic [CW-1:0] hcnt_o, vcnt_o, line_len_o, frame_lines_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dvp_pixel_decode #(
    .DW(8), .FRAME_WAIT(FW), .CNT_W(CW), .VS_INVERT(1), .GRID_LOG2(GL), .BAR_LOG2(BL)
  ) dut (
    .cmos_pclk_i   (clk),
    .rst_n_i       (rst_n),
    .cmos_href_i   (href),
    .cmos_vsync_i  (vsync),
    .cmos_data_i   (data),
    .mode_i        (mode),
    .vs_o          (vs_o),
    .hs_o          (hs_o),
    .de_o          (de_o),
    .rgb_o         (rgb_o),
    .hcnt_o        (hcnt_o),
    .vcnt_o        (vcnt_o),
    .line_len_o    (line_len_o),
    .frame_lines_o (frame_lines_o),
    .out_en_o      (out_en_o),
    .odd_line_o    (odd_line_o)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int vs_count = 0;         // frame starts since reset
  logic [1:0] frame_mode = 2'd0;
  int line_idx = 0;         // lines sent in the current frame

  function automatic logic [23:0] ref_pixel(input int m, input int h, input int v,
                                            input int b0, input int b1);
    int w;
    logic [23:0] px;
    case (m)
      0: begin
        w  = b0 * 256 + b1;
        px = {8'((w >> 11) << 3), 8'(((w >> 5) & 63) << 2), 8'((w & 31) << 3)};
      end
      1: px = 24'(b1 * 32'h010101);
      2: px = (((h >> GL) & 1) == ((v >> GL) & 1)) ? 24'hFFFFFF : 24'h000000;
      default: px = bar_tab[(h >> BL) % 8];
    endcase
    return px;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  int hs_cnt = 0, vs_cnt = 0, odd_cnt = 0, hs_run = 0;
  bit mon_on = 1'b0;

  always @(negedge clk) begin
    if (hs_o) hs_run++; else hs_run = 0;
    if (hs_o) hs_cnt++;
    if (vs_o) vs_cnt++;
    if (odd_line_o) odd_cnt++;
    if (mon_on && de_o) begin
      if (exp_q.size() == 0) begin
        check("de_unexpected", de_o, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("rgb", rgb_o, e[75:52]);
        check("hcnt", hcnt_o, e[51:40]);
        check("vcnt", vcnt_o, e[39:28]);
        check("de_cycle", 20'(cyc), e[27:8]);
        check("hs_align", 8'(hs_run), e[7:0]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vs"}, vs_o, 1'b0);
    check({tag, "_hs"}, hs_o, 1'b0);
    check({tag, "_de"}, de_o, 1'b0);
    check({tag, "_rgb"}, rgb_o, 24'h0);
    check({tag, "_hcnt"}, hcnt_o, 0);
    check({tag, "_vcnt"}, vcnt_o, 0);
    check({tag, "_line_len"}, line_len_o, 0);
    check({tag, "_frame_lines"}, frame_lines_o, 0);
    check({tag, "_out_en"}, out_en_o, 1'b0);
    check({tag, "_odd"}, odd_line_o, 1'b0);
  endtask

  // Sensor vsync is active-low; two-cycle pulse.
  task automatic vsync_pulse(input logic [1:0] m);
    int vs0;
    vs0  = vs_cnt;
    mode = m;
    tick(1);
    vsync = 1'b0;
    tick(2);
    vsync = 1'b1;
    tick(4);
    vs_count++;
    frame_mode = m;
    check("out_en", out_en_o, (vs_count >= FW));
    check("frame_lines", frame_lines_o, line_idx);
    check("vs_gate", vs_cnt - vs0, (vs_count >= FW) ? 2 : 0);
    line_idx = 0;
  endtask

  // kind: 0 = F8,00 pairs, 1 = constant 5A, 2 = random bytes
  task automatic send_line(input int nbytes, input int kind);
    int b[$];
    int np, t0, hs0, odd0;
    bit two, en;
    two = (frame_mode != 2'd1);
    en  = (vs_count >= FW);
    for (int i = 0; i < nbytes; i++) begin
      if (kind == 0)      b.push_back((i % 2 == 0) ? 'hF8 : 'h00);
      else if (kind == 1) b.push_back('h5A);
      else                b.push_back(int'($urandom_range(0, 255)));
    end
    np = two ? nbytes / 2 : nbytes;
    t0 = cyc + 1;
    if (en) begin
      for (int p = 0; p < np; p++) begin
        exp_q.push_back({ref_pixel(frame_mode, p, line_idx,
                                   two ? b[2*p] : 0, two ? b[2*p+1] : b[p]),
                         12'(p), 12'(line_idx),
                         20'(two ? t0 + 2*p + 3 : t0 + p + 2),
                         8'(two ? 2*p + 2 : p + 1)});
      end
    end
    hs0  = hs_cnt;
    odd0 = odd_cnt;
    for (int i = 0; i < nbytes; i++) begin
      tick(1);
      href = 1'b1;
      data = 8'(b[i]);
    end
    tick(1);
    href = 1'b0;
    data = 8'($urandom_range(0, 255));
    tick(4);
    check("hs_cycles", hs_cnt - hs0, en ? nbytes : 0);
    check("odd_pulses", odd_cnt - odd0, (two && (nbytes % 2 == 1)) ? 1 : 0);
    check("line_len", line_len_o, np);
    line_idx++;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    href  = 1'b0;
    vsync = 1'b1;
    data  = 8'h00;
    mode  = 2'd0;
    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(2);
    mon_on = 1'b1;

    // RGB565 frames; output opens once FW frame starts have been seen
    for (int f = 0; f < 5; f++) begin
      vsync_pulse(2'd0);
      repeat (4) send_line(16, 0);
    end

    // RAW8: constant then random bytes, back-to-back strobes
    vsync_pulse(2'd1);
    send_line(16, 1);
    send_line(16, 2);

    // Grid, 6 lines so line 4 shows the inverted pattern
    vsync_pulse(2'd2);
    repeat (6) send_line(16, 2);

    // Odd line, then a mode change mid-frame that must not apply yet
    vsync_pulse(2'd0);
    send_line(7, 2);
    send_line(16, 2);
    mode = 2'd3;
    send_line(16, 2);

    // Colour bars across all 8 bars
    vsync_pulse(2'd3);
    send_line(32, 2);
    send_line(32, 2);

    // Reset in the middle of a line of an enabled frame
    vsync_pulse(2'd1);
    send_line(8, 2);
    mon_on = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      href = 1'b1;
      data = 8'($urandom_range(0, 255));
    end
    rst_n = 1'b0;
    tick(1);
    check_zero("midreset");
    rst_n = 1'b1;
    href  = 1'b0;
    exp_q.delete();
    vs_count   = 0;
    line_idx   = 0;
    frame_mode = 2'd0;
    tick(3);
    mon_on = 1'b1;
    for (int f = 0; f < FW; f++) begin
      vsync_pulse(2'd1);
      send_line(12, 2);
    end

    tick(5);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
